sdram_cmd_responder: RTL and testbench

Responder side of the DMA sequencer's SDRAM command interface. Once per C64 PHI2 cycle it samples the RAMRD/RAMWR strobes, REU address and write data, then runs one single-byte SDRAM access followed by one auto-refresh. It runs on the fast clock C25M. It owns the SDRAM power-up initialisation and keeps refresh running when PHI2 is stopped.

---
 rtl/sdram_cmd_responder.sv | 223 ++++++++++++++++++++++
 tb/tb_sdram_cmd_responder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_cmd_responder.sv
`timescale 1ns/1ps
// sdram_cmd_responder: SDRAM side of the REU DMA command interface.
// Each PHI2 fall starts a 14-cycle sequence of one single-byte access followed
// by one auto-refresh. The block also performs SDRAM power-up initialisation
// and issues standalone refreshes while PHI2 is stopped.
module sdram_cmd_responder #(
  parameter int INIT_WAIT   = 5000,
  parameter int REF_TIMEOUT = 256
) (
  input  logic        C25M,
  input  logic        nRESET,
  input  logic        PHI2,
  input  logic        RAMRD,
  input  logic        RAMWR,
  input  logic [23:0] RA,
  input  logic [7:0]  WRD,
  output logic [7:0]  RDD,
  output logic        Ready,
  output logic        CKE,
  output logic        nRCS,
  output logic        nRAS,
  output logic        nCAS,
  output logic        nRWE,
  output logic [1:0]  BA,
  output logic [11:0] A,
  output logic        DQM,
  output logic [7:0]  DQout,
  output logic        DQoe,
  input  logic [7:0]  DQin
);

  // Step counter must hold both the init wait and the 14-step access sequence.
  localparam int SW = ($clog2(INIT_WAIT + 1) < 4) ? 4 : $clog2(INIT_WAIT + 1);
  localparam int RW = $clog2(REF_TIMEOUT + 1);

  // {nRAS, nCAS, nRWE}
  localparam logic [2:0] CMD_ACT   = 3'b011;
  localparam logic [2:0] CMD_READ  = 3'b101;
  localparam logic [2:0] CMD_WRITE = 3'b100;
  localparam logic [2:0] CMD_PRE   = 3'b010;
  localparam logic [2:0] CMD_REF   = 3'b001;
  localparam logic [2:0] CMD_MRS   = 3'b000;
  localparam logic [2:0] CMD_NOP   = 3'b111;

  typedef enum logic [2:0] {
    S_INITWAIT, S_INITNOP, S_INITPRE, S_INITREF, S_INITMRS, S_IDLE, S_ACCESS, S_WDOG
  } stateT;

  stateT           state, nextState;
  logic [SW-1:0]   step, nextStep;
  logic [2:0]      refNum, nextRefNum;
  logic [RW-1:0]   refCnt;
  logic            phi2Meta, phi2Sync, phi2Prev, phi2Fall;
  logic            rdReq, wrReq;
  logic [1:0]      bankReg;
  logic [9:0]      colReg;
  logic [7:0]      dataReg;
  logic [2:0]      cmdNext;
  logic [1:0]      baNext;
  logic [11:0]     aNext;
  logic            ckeNext, readyNext, dqoeNext;
  logic [7:0]      dqoutNext;

  // Bring PHI2 into the C25M domain and keep one extra stage for fall detection.
  always_ff @(posedge C25M or negedge nRESET) begin
    if (!nRESET) begin
      phi2Meta <= 1'b0;
      phi2Sync <= 1'b0;
      phi2Prev <= 1'b0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // register samples the pre-edge value of its neighbours.
      phi2Meta <= PHI2;
      phi2Sync <= phi2Meta;
      phi2Prev <= phi2Sync;
    end
  end

  assign phi2Fall = phi2Prev & ~phi2Sync;

  // State register.
  always_ff @(posedge C25M or negedge nRESET) begin
    if (!nRESET) begin
      state  <= S_INITWAIT;
      step   <= '0;
      refNum <= '0;
    end else begin
      state  <= nextState;
      step   <= nextStep;
      refNum <= nextRefNum;
    end
  end

  // Next-state logic; step counts cycles spent in the current state.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal
    // unassigned, which would otherwise infer a latch.
    nextState  = state;
    nextStep   = step + SW'(1);
    nextRefNum = refNum;
    unique case (state)
      S_INITWAIT: if (step == SW'(INIT_WAIT - 1)) begin nextState = S_INITNOP; nextStep = '0; end
      S_INITNOP:  if (step == SW'(1)) begin nextState = S_INITPRE; nextStep = '0; end
      S_INITPRE:  if (step == SW'(2)) begin nextState = S_INITREF; nextStep = '0; nextRefNum = '0; end
      S_INITREF: begin
        if (step == SW'(3)) begin
          nextStep = '0;
          if (refNum == 3'd7) nextState = S_INITMRS;
          else                nextRefNum = refNum + 3'd1;
        end
      end
      S_INITMRS:  if (step == SW'(2)) begin nextState = S_IDLE; nextStep = '0; end
      S_IDLE: begin
        nextStep = '0;
        // The current idle cycle is the REF_TIMEOUT-th since the last refresh.
        if (phi2Fall)                              nextState = S_ACCESS;
        else if (refCnt >= RW'(REF_TIMEOUT - 1))   nextState = S_WDOG;
      end
      S_ACCESS:   if (step == SW'(13)) begin nextState = S_IDLE; nextStep = '0; end
      S_WDOG:     if (step == SW'(3)) begin nextState = S_IDLE; nextStep = '0; end
      default: begin nextState = S_INITWAIT; nextStep = '0; end
    endcase
  end

  // Output decode for the state being entered, so the registered pins show
  // each command during the cycle of its state.
  always_comb begin
    cmdNext   = CMD_NOP;
    baNext    = '0;
    aNext     = '0;
    dqoeNext  = 1'b0;
    dqoutNext = '0;
    ckeNext   = (nextState != S_INITWAIT);
    readyNext = nextState inside {S_IDLE, S_ACCESS, S_WDOG};
    case (nextState)
      S_INITPRE: if (nextStep == '0) begin cmdNext = CMD_PRE; aNext[10] = 1'b1; end
      S_INITREF: if (nextStep == '0) cmdNext = CMD_REF;
      S_INITMRS: if (nextStep == '0) begin cmdNext = CMD_MRS; aNext = 12'h020; end
      S_WDOG:    if (nextStep == '0) cmdNext = CMD_REF;
      S_ACCESS: begin
        if (nextStep == SW'(2)) begin
          if (RAMRD || RAMWR) begin
            cmdNext = CMD_ACT;
            baNext  = RA[23:22];
            aNext   = RA[21:10];
          end
        end else if (nextStep == SW'(4)) begin
          baNext = bankReg;
          aNext  = {1'b0, 1'b1, colReg};
          if (rdReq) begin
            cmdNext = CMD_READ;
          end else if (wrReq) begin
            cmdNext   = CMD_WRITE;
            dqoeNext  = 1'b1;
            dqoutNext = dataReg;
          end else begin
            baNext = '0;
            aNext  = '0;
          end
        end else if (nextStep == SW'(9)) begin
          cmdNext = CMD_REF;
        end
      end
      default: ;
    endcase
  end

  // Register all SDRAM-facing outputs.
  always_ff @(posedge C25M or negedge nRESET) begin
    if (!nRESET) begin
      CKE                <= 1'b0;
      nRCS               <= 1'b1;
      {nRAS, nCAS, nRWE} <= CMD_NOP;
      BA                 <= '0;
      A                  <= '0;
      DQM                <= 1'b1;
      DQoe               <= 1'b0;
      DQout              <= '0;
      Ready              <= 1'b0;
    end else begin
      CKE                <= ckeNext;
      nRCS               <= ~ckeNext;
      {nRAS, nCAS, nRWE} <= cmdNext;
      BA                 <= baNext;
      A                  <= aNext;
      DQM                <= ~readyNext;
      DQoe               <= dqoeNext;
      DQout              <= dqoutNext;
      Ready              <= readyNext;
    end
  end

  // Latch the request on entry to S2; a simultaneous write is dropped in favour of the read.
  always_ff @(posedge C25M or negedge nRESET) begin
    if (!nRESET) begin
      rdReq   <= 1'b0;
      wrReq   <= 1'b0;
      bankReg <= '0;
      colReg  <= '0;
      dataReg <= '0;
    end else if (nextState == S_ACCESS && nextStep == SW'(2)) begin
      rdReq   <= RAMRD;
      wrReq   <= RAMWR & ~RAMRD;
      bankReg <= RA[23:22];
      colReg  <= RA[9:0];
      dataReg <= WRD;
    end
  end

  // Capture read data at CAS latency 2: the edge that ends S6.
  always_ff @(posedge C25M or negedge nRESET) begin
    if (!nRESET)                                              RDD <= '0;
    else if (state == S_ACCESS && step == SW'(6) && rdReq)    RDD <= DQin;
  end

  // Count idle cycles since the last refresh to drive the refresh watchdog.
  always_ff @(posedge C25M or negedge nRESET) begin
    if (!nRESET)                                                  refCnt <= '0;
    else if (cmdNext == CMD_REF)                                  refCnt <= '0;
    else if (state == S_IDLE && refCnt != RW'(REF_TIMEOUT))       refCnt <= refCnt + RW'(1);
  end

endmodule

// File: tb/tb_sdram_cmd_responder.sv
`timescale 1ns/1ps
// Scoreboard bench for sdram_cmd_responder: stimulus queues expected SDRAM
// commands and read data; a negedge monitor pops and compares them as the DUT
// drives them, and also models the SDRAM data path with CAS latency 2.
module tb_sdram_cmd_responder;

  localparam int INIT_WAIT   = 20;
  localparam int REF_TIMEOUT = 32;

  localparam logic [2:0] C_ACT   = 3'b011;
  localparam logic [2:0] C_READ  = 3'b101;
  localparam logic [2:0] C_WRITE = 3'b100;
  localparam logic [2:0] C_PRE   = 3'b010;
  localparam logic [2:0] C_REF   = 3'b001;
  localparam logic [2:0] C_MRS   = 3'b000;
  localparam logic [2:0] C_NOP   = 3'b111;

  logic        C25M = 1'b0;
  logic        nRESET, PHI2, RAMRD, RAMWR;
  logic [23:0] RA;
  logic [7:0]  WRD, RDD, DQout;
  logic [7:0]  DQin = 8'h00;
  logic        Ready, CKE, nRCS, nRAS, nCAS, nRWE, DQM, DQoe;
  logic [1:0]  BA;
  logic [11:0] A;

  sdram_cmd_responder #(.INIT_WAIT(INIT_WAIT), .REF_TIMEOUT(REF_TIMEOUT)) dut (
    .C25M(C25M), .nRESET(nRESET), .PHI2(PHI2), .RAMRD(RAMRD), .RAMWR(RAMWR),
    .RA(RA), .WRD(WRD), .RDD(RDD), .Ready(Ready), .CKE(CKE), .nRCS(nRCS),
    .nRAS(nRAS), .nCAS(nCAS), .nRWE(nRWE), .BA(BA), .A(A), .DQM(DQM),
    .DQout(DQout), .DQoe(DQoe), .DQin(DQin)
  );

  always #20 C25M = ~C25M;

  typedef struct {
    logic [2:0]  cmd;
    logic        checkBa;
    logic [1:0]  ba;
    logic [11:0] a;
    logic [11:0] aMask;
    logic        dqoe;
    logic [7:0]  dqout;
    int          gap;    // cycles since previous command, -1 = don't care
    string       name;
  } cmdExpT;

  cmdExpT     expQ[$];
  logic [7:0] rddQ[$];
  int nChecks = 0;
  int nFails  = 0;

  // monitor / SDRAM model state
  int          cycle = 0;
  int          lastCmdCycle = 0;
  int          mrsCycle = 0;
  int          rddDue = -1;
  int          rdCnt = 0;
  int          writesSeen = 0;
  logic [7:0]  rdData = 8'h00;
  logic [7:0]  mem [logic [23:0]];
  logic [11:0] rowOf [4];
  logic        readyPrev = 1'b0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
    nChecks++;
    if (actual !== required) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, required, cycle);
    end
  endtask

  task automatic pushCmd(input logic [2:0] c, input logic cb, input logic [1:0] ba,
                         input logic [11:0] a, input logic [11:0] m, input logic oe,
                         input logic [7:0] d, input int gap, input string nm);
    cmdExpT e;
    e.cmd = c; e.checkBa = cb; e.ba = ba; e.a = a; e.aMask = m;
    e.dqoe = oe; e.dqout = d; e.gap = gap; e.name = nm;
    expQ.push_back(e);
  endtask

  task automatic pushInit();
    pushCmd(C_PRE, 1'b0, 2'd0, 12'h400, 12'h400, 1'b0, 8'h00, -1, "init_pre");
    pushCmd(C_REF, 1'b0, 2'd0, 12'h000, 12'h000, 1'b0, 8'h00, 3, "init_ref0");
    for (int i = 1; i < 8; i++)
      pushCmd(C_REF, 1'b0, 2'd0, 12'h000, 12'h000, 1'b0, 8'h00, 4, "init_ref");
    pushCmd(C_MRS, 1'b1, 2'd0, 12'h020, 12'hFFF, 1'b0, 8'h00, 4, "init_mrs");
  endtask

  // Expected commands for one access: ACT in S2, READ/WRITE in S4, REF in S9.
  task automatic pushAccess(input logic rd, input logic wr, input logic [23:0] ra,
                            input logic [7:0] wrd, input string nm);
    logic [11:0] colA;
    colA = {2'b01, ra[9:0]};
    if (rd || wr) begin
      pushCmd(C_ACT, 1'b1, ra[23:22], ra[21:10], 12'hFFF, 1'b0, 8'h00, -1, {nm, "_act"});
      if (rd) pushCmd(C_READ, 1'b1, ra[23:22], colA, 12'hFFF, 1'b0, 8'h00, 2, {nm, "_read"});
      else    pushCmd(C_WRITE, 1'b1, ra[23:22], colA, 12'hFFF, 1'b1, wrd, 2, {nm, "_write"});
      pushCmd(C_REF, 1'b0, 2'd0, 12'h000, 12'h000, 1'b0, 8'h00, 5, {nm, "_ref"});
    end else begin
      pushCmd(C_REF, 1'b0, 2'd0, 12'h000, 12'h000, 1'b0, 8'h00, -1, {nm, "_ref"});
    end
  endtask

  // Monitor: scoreboard compare, SDRAM memory model and read-data pipeline.
  always @(negedge C25M) begin : monitor
    logic [2:0]  cmd;
    cmdExpT      e;
    logic [23:0] key;
    logic [7:0]  expRdd;
    cycle++;
    DQin = 8'h00;
    if (rdCnt == 1) DQin = rdData;
    if (rdCnt > 0) rdCnt--;
    if (nRESET && CKE && !nRCS) begin
      cmd = {nRAS, nCAS, nRWE};
      if (cmd == C_NOP) begin
        check("dqoe_on_nop", DQoe, 1'b0);
      end else begin
        if (expQ.size() == 0) begin
          check("unexpected_cmd", cmd, C_NOP);
        end else begin
          e = expQ.pop_front();
          check({e.name, "_cmd"}, cmd, e.cmd);
          if (e.checkBa) check({e.name, "_ba"}, BA, e.ba);
          check({e.name, "_a"}, A & e.aMask, e.a & e.aMask);
          check({e.name, "_dqoe"}, DQoe, e.dqoe);
          if (e.dqoe) check({e.name, "_dqout"}, DQout, e.dqout);
          if (e.gap >= 0) check({e.name, "_gap"}, cycle - lastCmdCycle, e.gap);
        end
        if (cmd == C_ACT) begin
          check("act_before_ready", Ready, 1'b1);
          rowOf[BA] = A;
        end
        if (cmd == C_WRITE) begin
          mem[{BA, rowOf[BA], A[9:0]}] = DQout;
          writesSeen++;
        end
        if (cmd == C_READ) begin
          key    = {BA, rowOf[BA], A[9:0]};
          rdData = mem.exists(key) ? mem[key] : 8'h3C;
          rdCnt  = 2;
          rddDue = cycle + 3;
        end
        if (cmd == C_MRS) mrsCycle = cycle;
        lastCmdCycle = cycle;
      end
    end
    if (rddDue == cycle) begin
      rddDue = -1;
      if (rddQ.size() == 0) begin
        check("unexpected_read_rdd_queue", rddQ.size(), 1);
      end else begin
        expRdd = rddQ.pop_front();
        check("rdd_s7", RDD, expRdd);
      end
    end
    if (Ready && !readyPrev) check("ready_after_mrs", cycle - mrsCycle, 3);
    readyPrev = Ready;
  end

  task automatic waitReady(input int maxc);
    int n = 0;
    while (!Ready && n < maxc) begin @(negedge C25M); n++; end
    check("ready_timeout", Ready, 1'b1);
    check("dqm_after_ready", DQM, 1'b0);
  endtask

  task automatic waitDrain(input int maxc, input string nm);
    int n = 0;
    while (expQ.size() != 0 && n < maxc) begin @(negedge C25M); n++; end
    check({nm, "_drained"}, expQ.size(), 0);
  endtask

  task automatic runInit();
    @(negedge C25M);
    nRESET = 1'b1;
    repeat (INIT_WAIT - 1) begin
      @(negedge C25M);
      check("cke_low_init", CKE, 1'b0);
    end
    @(negedge C25M);
    check("cke_high_after_wait", CKE, 1'b1);
    check("cs_low_after_wait", nRCS, 1'b0);
    check("dqm_during_init", DQM, 1'b1);
    waitReady(200);
    waitDrain(10, "init");
  endtask

  // One PHI2 period of 20 C25M cycles; strobes change on the fall.
  task automatic phi2Cycle(input logic rd, input logic wr, input logic [23:0] ra, input logic [7:0] wrd);
    @(negedge C25M);
    RAMRD = rd; RAMWR = wr; RA = ra; WRD = wrd;
    PHI2 = 1'b0;
    repeat (10) @(negedge C25M);
    PHI2 = 1'b1;
    RAMRD = 1'b0; RAMWR = 1'b0;
    repeat (10) @(negedge C25M);
  endtask

  initial begin : stimulus
    int start;
    int n;
    nRESET = 1'b0; PHI2 = 1'b1; RAMRD = 1'b0; RAMWR = 1'b0; RA = '0; WRD = '0;
    repeat (3) @(negedge C25M);
    check("rst_cke", CKE, 1'b0);
    check("rst_cs", nRCS, 1'b1);
    check("rst_cmd", {nRAS, nCAS, nRWE}, C_NOP);
    check("rst_dqm", DQM, 1'b1);
    check("rst_ready", Ready, 1'b0);

    pushInit();
    runInit();

    // write then read back the same byte
    pushAccess(1'b0, 1'b1, 24'hC12345, 8'hA5, "wr1");
    phi2Cycle(1'b0, 1'b1, 24'hC12345, 8'hA5);
    waitDrain(5, "wr1");
    pushAccess(1'b1, 1'b0, 24'hC12345, 8'h00, "rd1");
    rddQ.push_back(8'hA5);
    phi2Cycle(1'b1, 1'b0, 24'hC12345, 8'h00);
    waitDrain(5, "rd1");

    // no strobes: refresh only, RDD held
    pushAccess(1'b0, 1'b0, 24'h000000, 8'h00, "idle");
    phi2Cycle(1'b0, 1'b0, 24'h123456, 8'h77);
    waitDrain(5, "idle");
    check("rdd_after_idle", RDD, 8'hA5);

    // read and write together: read wins, unwritten location returns model default
    pushAccess(1'b1, 1'b0, 24'h2003FF, 8'h00, "conflict");
    rddQ.push_back(8'h3C);
    phi2Cycle(1'b1, 1'b1, 24'h2003FF, 8'h99);
    waitDrain(5, "conflict");

    // highest address write and read back
    pushAccess(1'b0, 1'b1, 24'hFFFFFF, 8'h5A, "wrmax");
    phi2Cycle(1'b0, 1'b1, 24'hFFFFFF, 8'h5A);
    pushAccess(1'b1, 1'b0, 24'hFFFFFF, 8'h00, "rdmax");
    rddQ.push_back(8'h5A);
    phi2Cycle(1'b1, 1'b0, 24'hFFFFFF, 8'h00);
    waitDrain(5, "rdmax");

    // PHI2 stopped high: watchdog refreshes 36 cycles apart
    pushCmd(C_REF, 1'b0, 2'd0, 12'h000, 12'h000, 1'b0, 8'h00, -1, "wdog_ref0");
    pushCmd(C_REF, 1'b0, 2'd0, 12'h000, 12'h000, 1'b0, 8'h00, 36, "wdog_ref1");
    pushCmd(C_REF, 1'b0, 2'd0, 12'h000, 12'h000, 1'b0, 8'h00, 36, "wdog_ref2");
    waitDrain(150, "wdog");

    // reset asserted in S5 of a write
    pushAccess(1'b0, 1'b1, 24'h400010, 8'hC3, "abort");
    expQ.pop_back();   // the REF of this sequence is never reached
    start = writesSeen;
    n = 0;
    @(negedge C25M);
    RAMWR = 1'b1; RA = 24'h400010; WRD = 8'hC3; PHI2 = 1'b0;
    while (writesSeen == start && n < 40) begin @(posedge C25M); n++; end
    check("abort_write_seen", writesSeen - start, 1);
    #1;
    nRESET = 1'b0;
    #1;
    check("arst_cke", CKE, 1'b0);
    check("arst_cs", nRCS, 1'b1);
    check("arst_cmd", {nRAS, nCAS, nRWE}, C_NOP);
    check("arst_ba", BA, 2'd0);
    check("arst_a", A, 12'h000);
    check("arst_dqm", DQM, 1'b1);
    check("arst_dqoe", DQoe, 1'b0);
    check("arst_dqout", DQout, 8'h00);
    check("arst_rdd", RDD, 8'h00);
    check("arst_ready", Ready, 1'b0);
    check("abort_queue", expQ.size(), 0);
    PHI2 = 1'b1; RAMWR = 1'b0;
    repeat (3) @(negedge C25M);
    pushInit();
    runInit();
    check("rdd_after_reinit", RDD, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin : timeout
    #400000;
    $display("FAIL global_timeout: simulation did not complete, %0d checks, %0d failures", nChecks, nFails);
    $fatal(1, "timeout");
  end

endmodule
